alu_control_fsm: RTL and testbench

ALU_CONTROL_FSM -- requirements
Module: alu_control_fsm

---
 rtl/alu_control_fsm_if.sv | 29 ++
 rtl/alu_control_fsm.sv | 232 +++++++++++++++++++++++
 tb/tb_alu_control_fsm.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_control_fsm_if.sv
`default_nettype none
// alu_control_fsm_if: instruction handshake, ALU status and ALU control bundle.
// The master side issues instructions; the slave side is the control FSM.
interface alu_control_fsm_if;
  logic       InstrValid;
  logic       InstrReady;
  logic [3:0] Opcode;
  logic [2:0] Funct;
  logic       Set;
  logic       Overflow;
  logic [2:0] Op;
  logic       BInvert;
  logic       CIN;
  logic       Less;
  logic       RegWrite;
  logic       Done;
  logic       Exception;

  modport master (
    output InstrValid, Opcode, Funct, Set, Overflow,
    input  InstrReady, Op, BInvert, CIN, Less, RegWrite, Done, Exception
  );

  modport slave (
    input  InstrValid, Opcode, Funct, Set, Overflow,
    output InstrReady, Op, BInvert, CIN, Less, RegWrite, Done, Exception
  );
endinterface
`default_nettype wire

// File: rtl/alu_control_fsm.sv
`default_nettype none
// alu_control_fsm: multi-cycle ALU control sequencer (IDLE/DECODE/EXEC/SLT_SET/WB/ERR), all outputs registered.
// Optional macro ALU_CTRL_OVF_TRAP_EN: signed overflow on ADD/SUB/ADDI traps to ERR instead of writing back.
module alu_control_fsm (
  input wire logic         Clock,
  input wire logic         ResetN,
  alu_control_fsm_if.slave alu
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_SLT_SET = 3'd3,
    S_WB      = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  localparam logic [3:0] C_OPC_RTYPE = 4'b0000;
  localparam logic [3:0] C_OPC_ADDI  = 4'b0001;
  localparam logic [3:0] C_OPC_SLTI  = 4'b0010;

  localparam logic [2:0] C_FN_AND = 3'b000;
  localparam logic [2:0] C_FN_OR  = 3'b001;
  localparam logic [2:0] C_FN_ADD = 3'b010;
  localparam logic [2:0] C_FN_SUB = 3'b011;
  localparam logic [2:0] C_FN_XOR = 3'b100;
  localparam logic [2:0] C_FN_MOD = 3'b101;
  localparam logic [2:0] C_FN_SLT = 3'b110;

  localparam logic [2:0] C_OP_AND  = 3'b000;
  localparam logic [2:0] C_OP_OR   = 3'b001;
  localparam logic [2:0] C_OP_ADD  = 3'b010;
  localparam logic [2:0] C_OP_XOR  = 3'b011;
  localparam logic [2:0] C_OP_MOD  = 3'b100;
  localparam logic [2:0] C_OP_SLTI = 3'b101;
  localparam logic [2:0] C_OP_ADDI = 3'b110;
  localparam logic [2:0] C_OP_LESS = 3'b111;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_opcode;
  logic [2:0] r_funct;

  logic       r_ready;
  logic [2:0] r_op;
  logic       r_binvert;
  logic       r_cin;
  logic       r_less;
  logic       r_regwrite;
  logic       r_done;
  logic       r_exception;

  logic       w_ready_nxt;
  logic [2:0] w_op_nxt;
  logic       w_binvert_nxt;
  logic       w_cin_nxt;
  logic       w_less_nxt;
  logic       w_regwrite_nxt;
  logic       w_done_nxt;
  logic       w_exception_nxt;

  logic       w_handshake;
  logic       w_illegal;
  logic [2:0] w_dec_op;
  logic       w_dec_invert;
  logic       w_dec_slt;
  logic       w_dec_arith;
  logic       w_ovf_trap;

  assign w_handshake = (r_state == S_IDLE) && r_ready && alu.InstrValid;

  // Decode always works from the latched fields so bus activity after the handshake is ignored.
  always_comb begin
    w_illegal    = 1'b0;
    w_dec_op     = C_OP_AND;
    w_dec_invert = 1'b0;
    w_dec_slt    = 1'b0;
    w_dec_arith  = 1'b0;
    case (r_opcode)
      C_OPC_RTYPE: begin
        case (r_funct)
          C_FN_AND: w_dec_op = C_OP_AND;
          C_FN_OR:  w_dec_op = C_OP_OR;
          C_FN_ADD: begin
            w_dec_op    = C_OP_ADD;
            w_dec_arith = 1'b1;
          end
          C_FN_SUB: begin
            w_dec_op     = C_OP_ADD;
            w_dec_invert = 1'b1;
            w_dec_arith  = 1'b1;
          end
          C_FN_XOR: w_dec_op = C_OP_XOR;
          C_FN_MOD: w_dec_op = C_OP_MOD;
          C_FN_SLT: begin
            w_dec_op     = C_OP_ADD;
            w_dec_invert = 1'b1;
            w_dec_slt    = 1'b1;
          end
          default:  w_illegal = 1'b1;
        endcase
      end
      C_OPC_ADDI: begin
        w_dec_op    = C_OP_ADDI;
        w_dec_arith = 1'b1;
      end
      C_OPC_SLTI: begin
        w_dec_op     = C_OP_SLTI;
        w_dec_invert = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

`ifdef ALU_CTRL_OVF_TRAP_EN
  assign w_ovf_trap = w_dec_arith & alu.Overflow;
`else
  assign w_ovf_trap = 1'b0;
`endif

  // Outputs are computed for the state being entered, so registered values always match r_state.
  always_comb begin
    w_state_nxt     = r_state;
    w_ready_nxt     = 1'b0;
    w_op_nxt        = C_OP_AND;
    w_binvert_nxt   = 1'b0;
    w_cin_nxt       = 1'b0;
    w_less_nxt      = 1'b0;
    w_regwrite_nxt  = 1'b0;
    w_done_nxt      = 1'b0;
    w_exception_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_handshake) begin
          w_state_nxt = S_DECODE;
        end else begin
          w_ready_nxt = 1'b1;
        end
      end
      S_DECODE: begin
        if (w_illegal) begin
          w_state_nxt     = S_ERR;
          w_exception_nxt = 1'b1;
          w_done_nxt      = 1'b1;
        end else begin
          w_state_nxt   = S_EXEC;
          w_op_nxt      = w_dec_op;
          w_binvert_nxt = w_dec_invert;
          w_cin_nxt     = w_dec_invert;
        end
      end
      S_EXEC: begin
        if (w_dec_slt) begin
          // Set/Overflow here reflect the subtraction the ALU performed during EXEC.
          w_state_nxt   = S_SLT_SET;
          w_op_nxt      = C_OP_LESS;
          w_binvert_nxt = 1'b1;
          w_cin_nxt     = 1'b1;
          w_less_nxt    = alu.Set ^ alu.Overflow;
        end else if (w_ovf_trap) begin
          w_state_nxt     = S_ERR;
          w_exception_nxt = 1'b1;
          w_done_nxt      = 1'b1;
        end else begin
          w_state_nxt    = S_WB;
          w_regwrite_nxt = 1'b1;
          w_done_nxt     = 1'b1;
        end
      end
      S_SLT_SET: begin
        w_state_nxt    = S_WB;
        w_less_nxt     = r_less;
        w_regwrite_nxt = 1'b1;
        w_done_nxt     = 1'b1;
      end
      S_WB, S_ERR: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_op        <= C_OP_AND;
      r_binvert   <= 1'b0;
      r_cin       <= 1'b0;
      r_less      <= 1'b0;
      r_regwrite  <= 1'b0;
      r_done      <= 1'b0;
      r_exception <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ready     <= w_ready_nxt;
      r_op        <= w_op_nxt;
      r_binvert   <= w_binvert_nxt;
      r_cin       <= w_cin_nxt;
      r_less      <= w_less_nxt;
      r_regwrite  <= w_regwrite_nxt;
      r_done      <= w_done_nxt;
      r_exception <= w_exception_nxt;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_opcode <= 4'b0000;
      r_funct  <= 3'b000;
    end else if (w_handshake) begin
      r_opcode <= alu.Opcode;
      r_funct  <= alu.Funct;
    end
  end

  assign alu.InstrReady = r_ready;
  assign alu.Op         = r_op;
  assign alu.BInvert    = r_binvert;
  assign alu.CIN        = r_cin;
  assign alu.Less       = r_less;
  assign alu.RegWrite   = r_regwrite;
  assign alu.Done       = r_done;
  assign alu.Exception  = r_exception;

endmodule
`default_nettype wire

// File: tb/tb_alu_control_fsm.sv
`default_nettype none
// tb_alu_control_fsm: table-driven instruction vectors with a completion scoreboard, plus reset and bus-hold sequences.
module tb_alu_control_fsm;

  logic Clock;
  logic ResetN;
  int   n_checks;
  int   n_errors;
  int   cyc;
  int   hs_cyc;
  int   hs_count;

  alu_control_fsm_if bus ();

  alu_control_fsm dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .alu    (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    string      name;
    logic [3:0] opc;
    logic [2:0] fn;
    logic       set;
    logic       ovf;
    logic       hold;
    logic       illegal;
    logic       slt;
    logic [2:0] op;
    logic       inv;
    logic       less;
    int         lat;
    logic       rw;
    logic       exc;
  } vec_t;

  typedef struct {
    logic rw;
    logic exc;
    logic less;
    int   lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];

  function automatic void chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic vec_t mk(string nm, logic [3:0] opc, logic [2:0] fn, logic set, logic ovf,
                              logic illegal, logic slt, logic [2:0] op, logic inv, logic less,
                              int lat, logic rw, logic exc);
    vec_t v;
    v.name = nm; v.opc = opc; v.fn = fn; v.set = set; v.ovf = ovf; v.hold = 1'b0;
    v.illegal = illegal; v.slt = slt; v.op = op; v.inv = inv; v.less = less;
    v.lat = lat; v.rw = rw; v.exc = exc;
    return v;
  endfunction

  initial begin
    cyc = 0;
    forever begin
      @(posedge Clock);
      cyc++;
    end
  end

  // Completion monitor: every Done must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    hs_cyc   = 0;
    hs_count = 0;
    forever begin
      @(negedge Clock);
      if (ResetN && bus.InstrValid && bus.InstrReady) begin
        hs_cyc = cyc;
        hs_count++;
      end
      if (bus.Done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got Done=1 expected no completion");
        end else begin
          e = sb.pop_front();
          chk("done_regwrite", int'(bus.RegWrite), int'(e.rw));
          chk("done_exception", int'(bus.Exception), int'(e.exc));
          chk("done_less", int'(bus.Less), int'(e.less));
          chk("done_latency", cyc - hs_cyc, e.lat);
        end
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.InstrReady && n < 20) begin
      step();
      n++;
    end
    if (!bus.InstrReady) begin
      n_checks++;
      n_errors++;
      $display("FAIL ready_timeout: got InstrReady=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   n;
    int   hs_before;
    wait_ready();
    hs_before      = hs_count;
    bus.InstrValid = 1'b1;
    bus.Opcode     = v.opc;
    bus.Funct      = v.fn;
    bus.Set        = v.set;
    bus.Overflow   = v.ovf;
    e.rw = v.rw; e.exc = v.exc; e.less = v.less; e.lat = v.lat;
    sb.push_back(e);
    step();
    if (v.hold) begin
      bus.Opcode = 4'b0111;
      bus.Funct  = 3'b111;
    end else begin
      bus.InstrValid = 1'b0;
    end
    chk({v.name, "_decode_ready"}, int'(bus.InstrReady), 0);
    if (!v.illegal) begin
      step();
      chk({v.name, "_exec_op"}, int'(bus.Op), int'(v.op));
      chk({v.name, "_exec_binvert"}, int'(bus.BInvert), int'(v.inv));
      chk({v.name, "_exec_cin"}, int'(bus.CIN), int'(v.inv));
      if (v.slt) begin
        step();
        chk({v.name, "_sltset_op"}, int'(bus.Op), 7);
        chk({v.name, "_sltset_less"}, int'(bus.Less), int'(v.less));
        chk({v.name, "_sltset_binvert"}, int'(bus.BInvert & bus.CIN), 1);
      end
    end
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_done_timeout: got no Done expected Done within %0d cycles", v.name, v.lat);
      sb.delete();
    end
    chk({v.name, "_ready_after_done"}, int'(bus.InstrReady), 1);
    chk({v.name, "_handshakes"}, hs_count - hs_before, 1);
    bus.InstrValid = 1'b0;
    bus.Set        = 1'b0;
    bus.Overflow   = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic trap;
    n_checks = 0;
    n_errors = 0;
`ifdef ALU_CTRL_OVF_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    //            name     opc      fn      set  ovf  ill  slt  op      inv  less lat rw   exc
    vecs.push_back(mk("and",  4'b0000, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 3, 1, 0));
    vecs.push_back(mk("or",   4'b0000, 3'b001, 0, 0, 0, 0, 3'b001, 0, 0, 3, 1, 0));
    vecs.push_back(mk("add",  4'b0000, 3'b010, 0, 0, 0, 0, 3'b010, 0, 0, 3, 1, 0));
    vecs.push_back(mk("sub",  4'b0000, 3'b011, 1, 0, 0, 0, 3'b010, 1, 0, 3, 1, 0));
    vecs.push_back(mk("xor",  4'b0000, 3'b100, 0, 0, 0, 0, 3'b011, 0, 0, 3, 1, 0));
    vecs.push_back(mk("mod",  4'b0000, 3'b101, 0, 0, 0, 0, 3'b100, 0, 0, 3, 1, 0));
    vecs.push_back(mk("slt10", 4'b0000, 3'b110, 1, 0, 0, 1, 3'b010, 1, 1, 4, 1, 0));
    vecs.push_back(mk("slt11", 4'b0000, 3'b110, 1, 1, 0, 1, 3'b010, 1, 0, 4, 1, 0));
    vecs.push_back(mk("slt01", 4'b0000, 3'b110, 0, 1, 0, 1, 3'b010, 1, 1, 4, 1, 0));
    vecs.push_back(mk("fn111", 4'b0000, 3'b111, 0, 0, 1, 0, 3'b000, 0, 0, 2, 0, 1));
    vecs.push_back(mk("addi", 4'b0001, 3'b101, 0, 0, 0, 0, 3'b110, 0, 0, 3, 1, 0));
    vecs.push_back(mk("slti", 4'b0010, 3'b000, 1, 0, 0, 0, 3'b101, 1, 0, 3, 1, 0));
    vecs.push_back(mk("opc7", 4'b0111, 3'b010, 0, 0, 1, 0, 3'b000, 0, 0, 2, 0, 1));
    vecs.push_back(mk("opcF", 4'b1111, 3'b000, 0, 0, 1, 0, 3'b000, 0, 0, 2, 0, 1));
    vecs.push_back(mk("sub_ovf",  4'b0000, 3'b011, 0, 1, 0, 0, 3'b010, 1, 0, 3, !trap, trap));
    vecs.push_back(mk("add_ovf",  4'b0000, 3'b010, 1, 1, 0, 0, 3'b010, 0, 0, 3, !trap, trap));
    vecs.push_back(mk("addi_ovf", 4'b0001, 3'b000, 0, 1, 0, 0, 3'b110, 0, 0, 3, !trap, trap));
    vecs.push_back(mk("and_ovf",  4'b0000, 3'b000, 1, 1, 0, 0, 3'b000, 0, 0, 3, 1, 0));
    v = mk("hold", 4'b0000, 3'b010, 0, 0, 0, 0, 3'b010, 0, 0, 3, 1, 0);
    v.hold = 1'b1;
    vecs.push_back(v);

    ResetN         = 1'b0;
    bus.InstrValid = 1'b0;
    bus.Opcode     = 4'b0000;
    bus.Funct      = 3'b000;
    bus.Set        = 1'b0;
    bus.Overflow   = 1'b0;
    repeat (3) @(negedge Clock);
    chk("rst_ready", int'(bus.InstrReady), 0);
    chk("rst_op", int'(bus.Op), 0);
    chk("rst_flags", int'({bus.BInvert, bus.CIN, bus.Less, bus.RegWrite, bus.Done, bus.Exception}), 0);
    ResetN = 1'b1;
    step();
    chk("rst_release_ready", int'(bus.InstrReady), 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset asserted during SLT_SET: everything returns to idle at once and no completion follows.
    wait_ready();
    bus.InstrValid = 1'b1;
    bus.Opcode     = 4'b0000;
    bus.Funct      = 3'b110;
    bus.Set        = 1'b1;
    bus.Overflow   = 1'b0;
    step();
    bus.InstrValid = 1'b0;
    step();
    step();
    chk("abort_sltset_op", int'(bus.Op), 7);
    chk("abort_sltset_less", int'(bus.Less), 1);
    #2 ResetN = 1'b0;
    #1;
    chk("abort_op", int'(bus.Op), 0);
    chk("abort_flags", int'({bus.BInvert, bus.CIN, bus.Less, bus.RegWrite, bus.Done, bus.Exception}), 0);
    chk("abort_ready", int'(bus.InstrReady), 0);
    step();
    chk("abort_no_done", int'({bus.Done, bus.RegWrite, bus.Exception}), 0);
    @(negedge Clock);
    ResetN = 1'b1;
    step();
    chk("abort_resume_ready", int'(bus.InstrReady), 1);
    chk("abort_resume_done", int'(bus.Done), 0);

    run_vec(vecs[2]);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
